// File: rtl/control_unit.sv
// Hardwired control sequencer for a simple load/store CPU.
// Fetch occupies T0..T2; the opcode captured at the end of T2 selects the
// execute sequence in T3..T7. Strobes are decoded from the registered state
// and the latched opcode. In T6 of a branch, CON_FF also gates the PC update.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
    output logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONIn, Rin,
    output logic        Gra, Grb, Grc, Rout, IncPC, Read, Write,
    output logic        ADD, SUB, AND, OR,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_IN, C_OUT, C_HALT, C_NOP
    } class_e;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_e;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110, OP_BR   = 5'b10010, OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

    state_e     state, state_next;
    logic [4:0] op_q;
    class_e     cls;
    alu_e       alu;
    logic       alu_en;

    // Only the opcode field of IR steers the sequencer.
    logic unused_ir_low;
    assign unused_ir_low = ^IR[26:0];

    // State register; Clear forces RST at once, so every strobe drops without waiting for a clock.
    always_ff @(posedge Clock or posedge Clear) begin
        // NOTE: registers use <= so every flop samples pre-edge values; = here would create ordering races.
        if (Clear) state <= S_RST;
        else       state <= state_next;
    end

    // Opcode latch: captured on the T2->T3 edge, held through the execute phase.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)             op_q <= OP_NOP;
        else if (state == S_T2) op_q <= IR[31:27];
    end

    // Classify the latched opcode into an execute sequence and an ALU function.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable; a missed branch would infer a latch.
        cls = C_NOP;
        alu = ALU_ADD;
        case (op_q)
            OP_ADD:  begin cls = C_RTYPE; alu = ALU_ADD; end
            OP_SUB:  begin cls = C_RTYPE; alu = ALU_SUB; end
            OP_AND:  begin cls = C_RTYPE; alu = ALU_AND; end
            OP_OR:   begin cls = C_RTYPE; alu = ALU_OR;  end
            OP_ADDI: begin cls = C_IMM;   alu = ALU_ADD; end
            OP_ANDI: begin cls = C_IMM;   alu = ALU_AND; end
            OP_ORI:  begin cls = C_IMM;   alu = ALU_OR;  end
            OP_LDI:  cls = C_LDI;
            OP_LD:   cls = C_LD;
            OP_ST:   cls = C_ST;
            OP_BR:   cls = C_BR;
            OP_IN:   cls = C_IN;
            OP_OUT:  cls = C_OUT;
            OP_HALT: cls = C_HALT;
            default: cls = C_NOP;
        endcase
    end

    // Next-state sequencing: the instruction class decides where execution ends.
    always_comb begin
        state_next = S_RST;
        case (state)
            S_RST:  state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3:   case (cls)
                        C_IN, C_OUT, C_NOP: state_next = S_T0;
                        C_HALT:             state_next = S_HALT;
                        default:            state_next = S_T4;
                    endcase
            S_T4:   state_next = S_T5;
            S_T5:   state_next = (cls == C_LD || cls == C_ST || cls == C_BR) ? S_T6 : S_T0;
            S_T6:   state_next = (cls == C_BR) ? S_T0 : S_T7;
            S_T7:   state_next = S_T0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    // Strobe decode from state and instruction class.
    always_comb begin
        PCout = 1'b0; Zhiout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CONIn = 1'b0; Rin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rout = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
        alu_en = 1'b0;
        Run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_T1: begin Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: case (cls)
                      C_RTYPE, C_IMM:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                      C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                      C_BR:  begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
                      C_IN:  begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                      C_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                      default: ;
                  endcase
            S_T4: case (cls)
                      C_RTYPE: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
                      C_IMM:   begin Cout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
                      C_LDI, C_LD, C_ST: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                      C_BR:    begin PCout = 1'b1; Yin = 1'b1; end
                      default: ;
                  endcase
            S_T5: case (cls)
                      C_RTYPE, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                      C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                      C_BR:       begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                      default: ;
                  endcase
            S_T6: case (cls)
                      C_LD: begin Read = 1'b1; MDRin = 1'b1; end
                      C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                      C_BR: begin Zlowout = CON_FF; PCin = CON_FF; end
                      default: ;
                  endcase
            S_T7: case (cls)
                      C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                      C_ST: Write = 1'b1;
                      default: ;
                  endcase
            default: ;
        endcase
        if (alu_en) begin
            case (alu)
                ALU_ADD: ADD = 1'b1;
                ALU_SUB: SUB = 1'b1;
                ALU_AND: AND = 1'b1;
                ALU_OR:  OR  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table of instruction sequences plus
// hand-written Clear-mid-instruction and halt sequences, checked via a scoreboard.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        CON_FF;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONIn, Rin;
    logic Gra, Grb, Grc, Rout, IncPC, Read, Write;
    logic ADD, SUB, AND, OR, Run;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
        .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONIn(CONIn), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .IncPC(IncPC), .Read(Read), .Write(Write),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Run(Run)
    );

    always #5 Clock = ~Clock;

    // All outputs packed into one observation word.
    logic [31:0] obs;
    assign obs = {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONIn, Rin,
                  Gra, Grb, Grc, Rout, IncPC, Read, Write, ADD, SUB, AND, OR, Run};

    localparam logic [31:0] S_PCOUT = 32'd1 << 31, S_ZLOW  = 32'd1 << 29, S_MDROUT = 32'd1 << 28;
    localparam logic [31:0] S_INPORT = 32'd1 << 25, S_COUT = 32'd1 << 24, S_BAOUT = 32'd1 << 23;
    localparam logic [31:0] S_MARIN = 32'd1 << 22, S_ZIN   = 32'd1 << 21, S_PCIN  = 32'd1 << 20;
    localparam logic [31:0] S_MDRIN = 32'd1 << 19, S_IRIN  = 32'd1 << 18, S_YIN   = 32'd1 << 17;
    localparam logic [31:0] S_OUTPIN = 32'd1 << 14, S_CONIN = 32'd1 << 13, S_RIN  = 32'd1 << 12;
    localparam logic [31:0] S_GRA   = 32'd1 << 11, S_GRB   = 32'd1 << 10, S_GRC   = 32'd1 << 9;
    localparam logic [31:0] S_ROUT  = 32'd1 << 8,  S_INCPC = 32'd1 << 7,  S_READ  = 32'd1 << 6;
    localparam logic [31:0] S_WRITE = 32'd1 << 5,  S_ADD   = 32'd1 << 4,  S_SUB   = 32'd1 << 3;
    localparam logic [31:0] S_AND   = 32'd1 << 2,  S_OR    = 32'd1 << 1,  S_RUN   = 32'd1;

    localparam logic [31:0] F0 = S_PCOUT | S_MARIN | S_INCPC;
    localparam logic [31:0] F1 = S_READ | S_MDRIN;
    localparam logic [31:0] F2 = S_MDROUT | S_IRIN;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        int          len;
        logic [31:0] t3, t4, t5, t6, t7;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    vec_t vecs[16];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(string name, logic [31:0] ir, logic con, int len,
                                logic [31:0] t3, logic [31:0] t4, logic [31:0] t5,
                                logic [31:0] t6, logic [31:0] t7);
        vec_t v;
        v.name = name; v.ir = ir; v.con = con; v.len = len;
        v.t3 = t3; v.t4 = t4; v.t5 = t5; v.t6 = t6; v.t7 = t7;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the current outputs,
    // plus the per-cycle exclusivity rules.
    task automatic pop_and_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check(e.name, obs, e.exp);
        check({e.name, "_one_bus"}, {31'd0, $countones(obs[31:23]) <= 1}, 32'd1);
        check({e.name, "_one_alu"}, {31'd0, $countones(obs[4:1]) <= 1}, 32'd1);
        check({e.name, "_rd_wr"}, {31'd0, !(Read && Write)}, 32'd1);
    endtask

    function automatic logic [31:0] cycle_exp(vec_t v, int c);
        case (c)
            0: return F0 | S_RUN;
            1: return F1 | S_RUN;
            2: return F2 | S_RUN;
            3: return v.t3 | S_RUN;
            4: return v.t4 | S_RUN;
            5: return v.t5 | S_RUN;
            6: return v.t6 | S_RUN;
            default: return v.t7 | S_RUN;
        endcase
    endfunction

    // Run the first n cycles of an instruction, starting at a negedge just
    // before the T0 edge and ending at the negedge of the last cycle run.
    task automatic run_partial(input vec_t v, input int n);
        IR     = v.ir | ($urandom & 32'h07FF_FFFF);
        CON_FF = v.con;
        for (int c = 0; c < n; c++) begin
            exp_t e;
            e.name = $sformatf("%s_c%0d", v.name, c);
            e.exp  = cycle_exp(v, c);
            sb_q.push_back(e);
            @(posedge Clock);
            @(negedge Clock);
            pop_and_check();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk("add",  32'h1800_0000, 1'b0, 6, S_GRB|S_ROUT|S_YIN, S_GRC|S_ROUT|S_ADD|S_ZIN, S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[1]  = mk("sub",  32'h2000_0000, 1'b0, 6, S_GRB|S_ROUT|S_YIN, S_GRC|S_ROUT|S_SUB|S_ZIN, S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[2]  = mk("and",  32'h2800_0000, 1'b0, 6, S_GRB|S_ROUT|S_YIN, S_GRC|S_ROUT|S_AND|S_ZIN, S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[3]  = mk("or",   32'h3000_0000, 1'b0, 6, S_GRB|S_ROUT|S_YIN, S_GRC|S_ROUT|S_OR|S_ZIN,  S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[4]  = mk("addi", 32'h6000_0000, 1'b0, 6, S_GRB|S_ROUT|S_YIN, S_COUT|S_ADD|S_ZIN, S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[5]  = mk("andi", 32'h6800_0000, 1'b0, 6, S_GRB|S_ROUT|S_YIN, S_COUT|S_AND|S_ZIN, S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[6]  = mk("ori",  32'h7000_0000, 1'b0, 6, S_GRB|S_ROUT|S_YIN, S_COUT|S_OR|S_ZIN,  S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[7]  = mk("ldi",  32'h0800_0000, 1'b0, 6, S_GRB|S_BAOUT|S_YIN, S_COUT|S_ADD|S_ZIN, S_ZLOW|S_GRA|S_RIN, 0, 0);
        vecs[8]  = mk("ld",   32'h0000_0000, 1'b0, 8, S_GRB|S_BAOUT|S_YIN, S_COUT|S_ADD|S_ZIN, S_ZLOW|S_MARIN,
                      S_READ|S_MDRIN, S_MDROUT|S_GRA|S_RIN);
        vecs[9]  = mk("st",   32'h1000_0000, 1'b1, 8, S_GRB|S_BAOUT|S_YIN, S_COUT|S_ADD|S_ZIN, S_ZLOW|S_MARIN,
                      S_GRA|S_ROUT|S_MDRIN, S_WRITE);
        vecs[10] = mk("br_t", 32'h9000_0000, 1'b1, 7, S_GRA|S_ROUT|S_CONIN, S_PCOUT|S_YIN, S_COUT|S_ADD|S_ZIN, S_ZLOW|S_PCIN, 0);
        vecs[11] = mk("br_f", 32'h9000_0000, 1'b0, 7, S_GRA|S_ROUT|S_CONIN, S_PCOUT|S_YIN, S_COUT|S_ADD|S_ZIN, 0, 0);
        vecs[12] = mk("in",   32'hB000_0000, 1'b0, 4, S_INPORT|S_GRA|S_RIN, 0, 0, 0, 0);
        vecs[13] = mk("out",  32'hB800_0000, 1'b0, 4, S_GRA|S_ROUT|S_OUTPIN, 0, 0, 0, 0);
        vecs[14] = mk("nop",  32'hD000_0000, 1'b0, 4, 0, 0, 0, 0, 0);
        vecs[15] = mk("unl",  32'hF800_0000, 1'b1, 4, 0, 0, 0, 0, 0);

        // Reset state: everything low while Clear is held.
        Clear = 1'b1; IR = 32'h0; CON_FF = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset_state", obs, 32'd0);
        Clear = 1'b0;

        // Back-to-back instructions; each one's T0 confirms the previous one's length.
        foreach (vecs[i]) run_partial(vecs[i], vecs[i].len);

        // Clear mid-load at T6: strobes drop without a clock edge, fetch resumes after release.
        run_partial(vecs[8], 7);
        #2 Clear = 1'b1;
        #1 check("clear_async", obs, 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        check("clear_held", obs, 32'd0);
        Clear = 1'b0;
        run_partial(vecs[14], 4);

        // Halt: T3 then HALT with everything low for 20 cycles, Clear restores fetch.
        run_partial(mk("halt", 32'hD800_0000, 1'b0, 4, 0, 0, 0, 0, 0), 4);
        for (int k = 0; k < 20; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            check($sformatf("halt_idle_%0d", k), obs, 32'd0);
        end
        Clear = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Clear = 1'b0;
        run_partial(vecs[0], 6);
        run_partial(vecs[14], 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  in  1  single clock; all state changes on rising edge.
REQ-002 Clear  in  1  reset, asynchronous, active-high.
REQ-003 IR  in  32  current instruction; opcode = IR[31:27].
REQ-004 CON_FF  in  1  branch-condition flag from datapath CON logic, sampled in T6.
REQ-005 Bus-out strobes  out  1 each: PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout.
REQ-006 Load strobes  out  1 each: MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONIn, Rin.
REQ-007 Register-select and memory  out  1 each: Gra, Grb, Grc, Rout, IncPC, Read, Write.
REQ-008 ALU op  out  1 each: ADD, SUB, AND, OR; at most one high per cycle.
REQ-009 Run  out  1  high while executing, low in RST and HALT.

Function
REQ-010 States: RST, T0..T7, HALT; one state per clock; outputs SHALL be Moore, decoded from registered state plus latched opcode.
REQ-011 RST: all outputs low; next state T0.
REQ-012 T0: PCout, MARin, IncPC. T1: Read, MDRin. T2: MDRout, IRin.
REQ-013 Opcode SHALL be latched from IR at the T2->T3 edge and held until next T2.
REQ-014 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, in 10110, out 10111, nop 11010, halt 11011.
REQ-015 R-type (add/sub/and/or): T3 Grb,Rout,Yin; T4 Grc,Rout,op,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-016 Immediate (addi->ADD, andi->AND, ori->OR): T3 Grb,Rout,Yin; T4 Cout,op,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-017 ldi: T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-018 ld: T3-T4 as ldi; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-019 st: T3-T5 as ld; T6 Gra,Rout,MDRin (Read low); T7 Write; then T0.
REQ-020 br: T3 Gra,Rout,CONIn; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout,PCin only if CON_FF=1, else no strobes; then T0.
REQ-021 in: T3 InPortout,Gra,Rin; then T0. out: T3 Gra,Rout,OutPortin; then T0.
REQ-022 nop and every unlisted opcode: T3 with no strobes; then T0.
REQ-023 halt: T3 -> HALT; HALT holds with all strobes low and Run=0 until Clear.
REQ-024 Instruction lengths: in/out/nop = 4 cycles; R-type/imm/ldi = 6; br = 7; ld/st = 8.
REQ-025 Exactly one bus-out strobe high in any cycle that drives the bus; never two.
REQ-026 Read and Write SHALL never be high in the same cycle.

Reset
REQ-027 Clear high SHALL force state RST and all outputs low immediately, independent of Clock, including mid-instruction.
REQ-028 Latched opcode SHALL reset to nop.
REQ-029 After Clear falls, first rising edge enters T0; Run=1 from T0 onward.

Verification
REQ-030 Clear pulse during ld at T6 -> Read, MDRin drop asynchronously; next edge after release -> T0 with PCout,MARin,IncPC.
REQ-031 IR=0x18000000 (add) after fetch -> T3 Grb,Rout,Yin; T4 Grc,Rout,ADD,Zin; T5 Zlowout,Gra,Rin; next T0 on cycle 6.
REQ-032 IR=0x10000000 (st) -> T6 MDRin without Read; T7 Write only; Read/Write never overlap across 8 cycles.
REQ-033 IR=0x90000000 (br), CON_FF=1 at T6 -> Zlowout,PCin in T6; repeat with CON_FF=0 -> no strobes in T6; T0 follows both.
REQ-034 IR=0xD8000000 (halt) -> HALT after T3, Run=0, all strobes low for 20 cycles; Clear restores fetch.
REQ-035 IR=0xF8000000 (unlisted 11111) -> nop behaviour, back to T0 after 4 cycles; every cycle checked for at most one bus-out strobe and at most one ALU op.
